// File: rtl/bach_avl_mem_slave_pkg.sv
// Shared types and constants for the Avalon-MM burst memory slave.
package bach_avl_pkg;

  localparam int unsigned ADDR_W = 23;
  localparam int unsigned BC_W   = 3;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  // 8-bit Fibonacci LFSR used for wait-request injection: taps 8,6,5,4
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_WR   = 3'b010,
    ST_RD   = 3'b100
  } avlState_t;

  function automatic logic [7:0] lfsrNext(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

  // Beats left after the first one; a burst count of 0 behaves as 1.
  function automatic logic [BC_W-1:0] burstRemain(input logic [BC_W-1:0] cnt);
    return (cnt == '0) ? '0 : cnt - 1'b1;
  endfunction

endpackage

// File: rtl/bach_avl_mem_slave_if.sv
// Avalon-MM burst bus between the arbiter's downstream master and the memory slave.
interface bach_avl_mem_slave_if;
  import bach_avl_pkg::*;

  logic [ADDR_W-1:0] AvlAddress;
  logic              AvlWaitRequest;
  logic [BC_W-1:0]   AvlBurstCount;
  logic [BE_W-1:0]   AvlByteEnable;
  logic              AvlBeginBurstTransfer;
  logic              AvlRead;
  logic [DATA_W-1:0] AvlReadData;
  logic              AvlReadDataValid;
  logic              AvlWrite;
  logic [DATA_W-1:0] AvlWriteData;

  modport master (
    output AvlAddress, AvlBurstCount, AvlByteEnable, AvlBeginBurstTransfer,
           AvlRead, AvlWrite, AvlWriteData,
    input  AvlWaitRequest, AvlReadData, AvlReadDataValid
  );

  modport slave (
    input  AvlAddress, AvlBurstCount, AvlByteEnable, AvlBeginBurstTransfer,
           AvlRead, AvlWrite, AvlWriteData,
    output AvlWaitRequest, AvlReadData, AvlReadDataValid
  );

endinterface

// File: rtl/bach_avl_mem_slave_rd_pipe.sv
// RD_LAT-deep {valid, data} delay line for read beats; flushed by Rstn.
// Each data stage only loads when a valid beat enters it, so the output
// data holds the last returned beat while valid is low.
module bach_avl_rd_pipe
  import bach_avl_pkg::*;
#(
  parameter int unsigned RD_LAT = 2
) (
  input  logic              Clk,
  input  logic              Rstn,
  input  logic              InValid,
  input  logic [DATA_W-1:0] InData,
  output logic              OutValid,
  output logic [DATA_W-1:0] OutData
);

  logic [RD_LAT-1:0] validSr;
  logic [DATA_W-1:0] dataSr [RD_LAT];

  // Shift beats one stage per cycle; asynchronous flush discards in-flight beats
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      validSr <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) dataSr[i] <= '0;
    end else begin
      validSr[0] <= InValid;
      if (InValid) dataSr[0] <= InData;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        validSr[i] <= validSr[i-1];
        if (validSr[i-1]) dataSr[i] <= dataSr[i-1];
      end
    end
  end

  assign OutValid = validSr[RD_LAT-1];
  assign OutData  = dataSr[RD_LAT-1];

endmodule

// File: rtl/bach_avl_mem_slave.sv
// Avalon-MM burst slave backed by a 2^MEM_AW x 32-bit on-chip memory.
// Optional build macro: BACH_AVL_SLAVE_WAIT_INJECT_EN enables LFSR-driven
// wait-request injection in IDLE and WR.
module bach_avl_mem_slave
  import bach_avl_pkg::*;
#(
  parameter int unsigned MEM_AW = 10,
  parameter int unsigned RD_LAT = 2
) (
  input logic                  Clk,
  input logic                  Rstn,
  bach_avl_mem_slave_if.slave  avl
);

  localparam int unsigned DEPTH = 2 ** MEM_AW;

  logic [DATA_W-1:0] mem [DEPTH];

  avlState_t         state;
  logic [MEM_AW-1:0] addrQ;
  logic [BC_W-1:0]   remQ;
  logic              waitQ;
  logic              stallInj;
  logic              waitReq;

  logic [MEM_AW-1:0] cmdIdx;
  logic [BC_W-1:0]   remInit;
  logic              wrBeat;
  logic              rdIssue;
  logic [MEM_AW-1:0] wrIdx;
  logic [MEM_AW-1:0] rdIdx;
  logic [DATA_W-1:0] rdData;

  logic unusedBits;
  assign unusedBits = ^{avl.AvlBeginBurstTransfer, avl.AvlAddress[ADDR_W-1:MEM_AW]};

  assign cmdIdx  = avl.AvlAddress[MEM_AW-1:0];
  assign remInit = burstRemain(avl.AvlBurstCount);

`ifdef BACH_AVL_SLAVE_WAIT_INJECT_EN
  logic [7:0] lfsr;

  // Free-running stall generator
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) lfsr <= LFSR_SEED;
    else       lfsr <= lfsrNext(lfsr);
  end

  assign stallInj = lfsr[0] & (state != ST_RD);
`else
  assign stallInj = 1'b0;
`endif

  assign waitReq            = waitQ | stallInj;
  assign avl.AvlWaitRequest = waitReq;

  // Decode which beat (if any) moves this cycle and at which memory index
  always_comb begin
    wrBeat  = 1'b0;
    rdIssue = 1'b0;
    wrIdx   = cmdIdx;
    rdIdx   = cmdIdx;
    case (state)
      ST_IDLE: begin
        wrBeat  = avl.AvlWrite & ~waitReq;
        rdIssue = avl.AvlRead & ~avl.AvlWrite & ~waitReq;
      end
      ST_WR: begin
        wrBeat = avl.AvlWrite & ~waitReq;
        wrIdx  = addrQ;
      end
      ST_RD: begin
        rdIssue = 1'b1;
        rdIdx   = addrQ;
      end
      default: ;
    endcase
  end

  // Burst FSM; waitQ is registered so it tracks the state being entered
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      state <= ST_IDLE;
      addrQ <= '0;
      remQ  <= '0;
      waitQ <= 1'b1;
    end else begin
      waitQ <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (wrBeat || rdIssue) begin
            addrQ <= cmdIdx + 1'b1;
            remQ  <= remInit;
            if (remInit != '0) begin
              if (wrBeat) begin
                state <= ST_WR;
              end else begin
                state <= ST_RD;
                waitQ <= 1'b1;
              end
            end
          end
        end
        ST_WR: begin
          if (wrBeat) begin
            addrQ <= addrQ + 1'b1;
            remQ  <= remQ - 1'b1;
            if (remQ == BC_W'(1)) state <= ST_IDLE;
          end
        end
        ST_RD: begin
          addrQ <= addrQ + 1'b1;
          remQ  <= remQ - 1'b1;
          if (remQ == BC_W'(1)) state <= ST_IDLE;
          else                  waitQ <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Byte-lane masked write port; memory is deliberately not reset
  always_ff @(posedge Clk) begin
    if (wrBeat) begin
      for (int unsigned b = 0; b < BE_W; b++) begin
        if (avl.AvlByteEnable[b]) mem[wrIdx][8*b +: 8] <= avl.AvlWriteData[8*b +: 8];
      end
    end
  end

  assign rdData = mem[rdIdx];

  bach_avl_rd_pipe #(
    .RD_LAT (RD_LAT)
  ) uRdPipe (
    .Clk      (Clk),
    .Rstn     (Rstn),
    .InValid  (rdIssue),
    .InData   (rdData),
    .OutValid (avl.AvlReadDataValid),
    .OutData  (avl.AvlReadData)
  );

endmodule

// File: tb/tb_bach_avl_mem_slave.sv
// Directed bench for bach_avl_mem_slave with a read-beat scoreboard.
// Also builds with BACH_AVL_SLAVE_WAIT_INJECT_EN defined.
`timescale 1ns/1ps
module tb_bach_avl_mem_slave;
  import bach_avl_pkg::*;

  localparam int unsigned MEM_AW = 10;
  localparam int unsigned RD_LAT = 2;
  localparam int unsigned DEPTH  = 1024;

  logic Clk  = 1'b0;
  logic Rstn = 1'b0;
  always #5 Clk = ~Clk;

  bach_avl_mem_slave_if avl ();

  bach_avl_mem_slave #(
    .MEM_AW (MEM_AW),
    .RD_LAT (RD_LAT)
  ) dut (
    .Clk  (Clk),
    .Rstn (Rstn),
    .avl  (avl)
  );

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sbQ[$];
  logic [31:0] mdl [DEPTH];
  int          cyc   = 0;
  int          tests = 0;
  int          fails = 0;

  always @(posedge Clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Read-return monitor: every valid beat must match the oldest expected beat
  always @(negedge Clk) begin
    if (avl.AvlReadDataValid === 1'b1) begin
      chk("valid_expected", 32'(sbQ.size() != 0), 32'd1);
      if (sbQ.size() != 0) begin
        exp_t e;
        e = sbQ.pop_front();
        chk("rd_data", avl.AvlReadData, e.data);
        chk("rd_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

`ifdef BACH_AVL_SLAVE_WAIT_INJECT_EN
  logic [7:0] lm;
  bit         injChk = 1'b0;
  int         stalls = 0;

  // Independent model of the injection LFSR (taps 8,6,5,4)
  always @(posedge Clk or negedge Rstn) begin
    if (!Rstn) lm = 8'hA5;
    else       lm = {lm[6:0], lm[7] ^ lm[5] ^ lm[4] ^ lm[3]};
  end

  always @(negedge Clk) begin
    if (injChk) begin
      chk("inj_wait", 32'(avl.AvlWaitRequest), 32'(lm[0]));
      if (avl.AvlWaitRequest === 1'b1) stalls++;
    end
  end
`endif

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic waitReady(input string tag);
    int n = 0;
    while (avl.AvlWaitRequest !== 1'b0 && n < 200) begin
      @(negedge Clk);
      n++;
    end
    chk({tag, "_ready"}, 32'(avl.AvlWaitRequest), 32'd0);
  endtask

  function automatic void mdlWrite(input int unsigned idx, input logic [3:0] be, input logic [31:0] d);
    for (int b = 0; b < 4; b++) if (be[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
  endfunction

  // Write burst of data base, base+1, ...; after beat 0 the address/count
  // inputs are scrambled, and 'gap' inserts an idle cycle after beat 0.
  task automatic writeBurst(input int unsigned addr, input int unsigned cnt, input logic [3:0] be,
                            input logic [31:0] base, input bit gap);
    int unsigned n   = (cnt == 0) ? 1 : cnt;
    int unsigned idx = addr % DEPTH;
    avl.AvlAddress            = 23'(addr);
    avl.AvlBurstCount         = 3'(cnt);
    avl.AvlByteEnable         = be;
    avl.AvlBeginBurstTransfer = 1'b1;
    for (int unsigned k = 0; k < n; k++) begin
      avl.AvlWrite     = 1'b1;
      avl.AvlWriteData = base + 32'(k);
      waitReady("wr");
      mdlWrite(idx, be, base + 32'(k));
      idx = (idx + 1) % DEPTH;
      @(negedge Clk);
      avl.AvlBeginBurstTransfer = 1'b0;
      avl.AvlAddress            = 23'h15A5A5;
      avl.AvlBurstCount         = 3'd7;
      if (gap && k == 0 && n > 1) begin
        avl.AvlWrite     = 1'b0;
        avl.AvlWriteData = '1;
        @(negedge Clk);
      end
    end
    avl.AvlWrite = 1'b0;
  endtask

  // Issue a read command and queue expected beats; returns at the negedge after accept
  task automatic readCmd(input int unsigned addr, input int unsigned cnt);
    int unsigned n = (cnt == 0) ? 1 : cnt;
    avl.AvlAddress    = 23'(addr);
    avl.AvlBurstCount = 3'(cnt);
    avl.AvlByteEnable = 4'h0;
    avl.AvlRead       = 1'b1;
    waitReady("rd");
    for (int unsigned k = 0; k < n; k++)
      sbQ.push_back('{mdl[(addr + k) % DEPTH], cyc + int'(k) + int'(RD_LAT)});
    @(negedge Clk);
    avl.AvlRead = 1'b0;
  endtask

  task automatic readBurst(input int unsigned addr, input int unsigned cnt,
                           input int unsigned expWait, input string tag);
    int unsigned wc = 0;
    readCmd(addr, cnt);
    while (avl.AvlWaitRequest === 1'b1 && wc < 20) begin
      wc++;
      @(negedge Clk);
    end
`ifndef BACH_AVL_SLAVE_WAIT_INJECT_EN
    chk({tag, "_wait_cycles"}, wc, expWait);
`endif
  endtask

  task automatic drain();
    int n = 0;
    while (sbQ.size() != 0 && n < 50) begin
      @(negedge Clk);
      n++;
    end
    chk("drain_empty", 32'(sbQ.size()), 32'd0);
  endtask

  initial begin
    avl.AvlAddress            = '0;
    avl.AvlBurstCount         = 3'd1;
    avl.AvlByteEnable         = 4'hF;
    avl.AvlBeginBurstTransfer = 1'b0;
    avl.AvlRead               = 1'b0;
    avl.AvlWrite              = 1'b0;
    avl.AvlWriteData          = '0;

    // Reset state
    repeat (2) @(negedge Clk);
    chk("rst_wait", 32'(avl.AvlWaitRequest), 32'd1);
    chk("rst_valid", 32'(avl.AvlReadDataValid), 32'd0);
    chk("rst_data", avl.AvlReadData, 32'd0);
    Rstn = 1'b1;
    #1 chk("rel_wait_before_edge", 32'(avl.AvlWaitRequest), 32'd1);
    @(negedge Clk);
    chk("rel_wait_after_edge", 32'(avl.AvlWaitRequest), 32'd0);

    // Single write and read
    writeBurst(32'h010, 1, 4'hF, 32'hDEADBEEF, 1'b0);
    readBurst(32'h010, 1, 0, "single");
    drain();

    // Burst across the top of memory, then wrapped and aliased reads
    writeBurst(32'h3FE, 4, 4'hF, 32'd1, 1'b0);
    readBurst(32'h3FE, 4, 3, "wrap_burst");
    drain();
    readBurst(32'h000, 1, 0, "wrapped_word");
    readBurst(32'h400010, 1, 0, "alias");
    drain();

    // Byte enables, including an all-zero beat
    writeBurst(32'h020, 1, 4'hF, 32'h11223344, 1'b0);
    writeBurst(32'h020, 1, 4'b0101, 32'hAABBCCDD, 1'b0);
    readBurst(32'h020, 1, 0, "byte_en");
    writeBurst(32'h020, 1, 4'h0, 32'hFFFFFFFF, 1'b0);
    readBurst(32'h020, 1, 0, "be_zero");
    drain();

    // Burst count 0 behaves as single beat
    writeBurst(32'h030, 0, 4'hF, 32'h30303030, 1'b0);
    readBurst(32'h030, 0, 0, "count0");
    drain();

    // Write burst with an idle beat and scrambled address/count during WR
    writeBurst(32'h040, 3, 4'hF, 32'h000000A0, 1'b1);
    readBurst(32'h040, 3, 2, "gap_burst");
    drain();

    // Write and read together: write wins, no read beat
    avl.AvlAddress    = 23'h050;
    avl.AvlBurstCount = 3'd1;
    avl.AvlByteEnable = 4'hF;
    avl.AvlWriteData  = 32'h55AA55AA;
    avl.AvlWrite      = 1'b1;
    avl.AvlRead       = 1'b1;
    waitReady("clash");
    mdlWrite(32'h050, 4'hF, 32'h55AA55AA);
    @(negedge Clk);
    avl.AvlWrite = 1'b0;
    avl.AvlRead  = 1'b0;
    repeat (RD_LAT + 2) @(negedge Clk);
    readBurst(32'h050, 1, 0, "clash_read");
    drain();

    // Read burst of 7 then an overlapping write while beats drain
    writeBurst(32'h100, 7, 4'hF, 32'hC0DE0000, 1'b0);
    readBurst(32'h100, 7, 6, "burst7");
    writeBurst(32'h100, 1, 4'hF, 32'h0BADF00D, 1'b0);
    drain();
    readBurst(32'h100, 1, 0, "after_overlap");
    drain();

    // Reset during beat 3 of a 6-beat read burst
    writeBurst(32'h200, 6, 4'hF, 32'h00000600, 1'b0);
    readCmd(32'h200, 6);
    @(negedge Clk);
    @(negedge Clk);
    #1 Rstn = 1'b0;
    sbQ.delete();
    #1;
    chk("midrst_valid", 32'(avl.AvlReadDataValid), 32'd0);
    chk("midrst_wait", 32'(avl.AvlWaitRequest), 32'd1);
    chk("midrst_data", avl.AvlReadData, 32'd0);
    repeat (2) @(negedge Clk);
    chk("midrst_wait_held", 32'(avl.AvlWaitRequest), 32'd1);
    Rstn = 1'b1;
    #1 chk("midrst_rel_wait", 32'(avl.AvlWaitRequest), 32'd1);
    @(negedge Clk);
    chk("midrst_wait_drop", 32'(avl.AvlWaitRequest), 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk("post_rst_no_valid", 32'(avl.AvlReadDataValid), 32'd0);
      @(negedge Clk);
    end
    readBurst(32'h010, 1, 0, "mem_kept");
    readBurst(32'h200, 6, 5, "burst6_after_rst");
    drain();

`ifdef BACH_AVL_SLAVE_WAIT_INJECT_EN
    begin
      int unsigned addrs [100];
      injChk = 1'b1;
      for (int i = 0; i < 100; i++) begin
        addrs[i] = $urandom_range(DEPTH - 1, 0);
        writeBurst(addrs[i], 1, 4'hF, $urandom, 1'b0);
      end
      for (int i = 0; i < 100; i++) readCmd(addrs[i], 1);
      drain();
      injChk = 1'b0;
      chk("inj_stalls_seen", 32'(stalls != 0), 32'd1);
    end
`endif

    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bach_avl_mem_slave.md
# bach_avl_mem_slave

Avalon-MM burst slave that terminates the arbiter's single downstream master port (the `di_*` bus). It accepts single and burst reads/writes, backs them with an on-chip word memory, and returns read data with a fixed pipeline latency. It is the responder side of the arbitration path and serves as the memory-controller model for integration and as a small on-chip memory target.

## Interface
- `MEM_AW`, default 10: memory index width; depth is 2^MEM_AW 32-bit words.
- `RD_LAT`, default 2: cycles from read-beat issue to `AvlReadDataValid`; legal range 1..4.
- `Clk`  in  1  clock; all logic is rising-edge.
- `Rstn`  in  1  asynchronous, active-low reset.
- `AvlAddress`  in  23  word address; only bits `[MEM_AW-1:0]` are used, upper bits alias.
- `AvlWaitRequest`  out  1  high means the command or write beat is not accepted this cycle.
- `AvlBurstCount`  in  3  beats per burst, 1..7; a value of 0 is treated as 1.
- `AvlByteEnable`  in  4  per-byte write enable; ignored on reads.
- `AvlBeginBurstTransfer`  in  1  informational only; not used for decode.
- `AvlRead`  in  1  read command.
- `AvlReadData`  out  32  read beat data.
- `AvlReadDataValid`  out  1  `AvlReadData` is valid this cycle.
- `AvlWrite`  in  1  write command or write beat.
- `AvlWriteData`  in  32  write beat data.

## Operation
- FSM states (one-hot): IDLE, WR, RD.
- **IDLE:** `AvlWaitRequest` is 0 (subject to injection, see Configuration).
  - `AvlWrite` with wait=0: write the beat, latch address+1 and remaining=count-1.
    - If remaining = 0, stay in IDLE; otherwise go to WR.
  - `AvlRead` with wait=0: issue beat 0, latch address+1 and remaining=count-1.
    - If remaining = 0, stay in IDLE; otherwise go to RD.
  - Write and read asserted together (protocol violation): the write wins and the read is dropped.
- **WR:** wait=0; each cycle with `AvlWrite` high writes one beat at the internal address.
  - Address increments by 1 and remaining decrements per beat.
  - `AvlAddress` and `AvlBurstCount` are ignored in this state.
  - After the last beat, return to IDLE.
  - Cycles with `AvlWrite` low are idle beats; the FSM holds.
- **RD:** wait=1; one beat is issued per cycle until remaining = 0, then return to IDLE.
- Memory index wraps modulo 2^MEM_AW within a burst (address 0x3FF+1 goes to 0x000).
- Read data is sampled from memory at the issue cycle.
  - A write accepted after a read beat has issued does not affect that beat's data.
- Read beats travel an `RD_LAT`-deep valid/data pipeline that is independent of the FSM.
  - A new command is accepted in IDLE while earlier read beats are still draining.
  - Return order is strict issue order.
- Byte lane b is written only when `AvlByteEnable[b]`=1. All-zero enables consume the beat with no memory change.
- **Reset:**
  - FSM goes to IDLE; the pipeline is flushed.
  - `AvlReadDataValid`=0, `AvlReadData`=0, `AvlWaitRequest`=1, counters=0.
  - Memory contents are not reset.
  - `AvlWaitRequest` drops to 0 on the first rising edge after `Rstn` deasserts.
- **Reset mid-burst:** in-flight beats are discarded and no `AvlReadDataValid` pulses appear after reset. A partial write burst leaves the beats already written in memory.

## Timing
- Write beat: committed at the rising edge where `AvlWrite`=1 and `AvlWaitRequest`=0. Zero latency, one beat per cycle.
- Read: command accepted at edge T.
  - Beat k issues at edge T+k.
  - Beat k's `AvlReadDataValid` is high in the cycle after edge T+k+RD_LAT-1, i.e. RD_LAT cycles after issue.
  - Valid beats are back-to-back with no gaps.
- `AvlWaitRequest` rises in the cycle after the read command is accepted. It falls in the cycle after the last beat issues.
- `AvlReadData` holds its last value while valid=0.

## Configuration
- `BACH_AVL_SLAVE_WAIT_INJECT_EN` defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 0xA5 on reset) advances every cycle.
  - When LFSR bit0=1, `AvlWaitRequest` is forced to 1 in IDLE and WR. No command or beat is accepted in such a cycle and the FSM holds.
  - RD state and the read pipeline are unaffected.
- Not defined: no LFSR is present and wait behaviour is exactly as in Operation.

## Structure
- Package `bach_avl_pkg`:
  - state encodings (IDLE=3'b001, WR=3'b010, RD=3'b100);
  - burst-count width 3;
  - data width 32;
  - LFSR seed and tap constants.
- Sub-module `bach_avl_rd_pipe`: parameterised `RD_LAT` shift register carrying {valid, data}, with asynchronous flush on `Rstn`.
- The memory is an inferred array inside the top module.

## Test plan
- Single write of 0xDEADBEEF to address 0x010 with BE=4'hF, then single read of 0x010 -> valid pulse RD_LAT cycles after accept carrying 0xDEADBEEF; wait is high for 0 cycles.
- Write burst of count 4 at 0x3FE with data 1,2,3,4, then read burst of count 4 at 0x3FE -> 4 consecutive valid beats 1,2,3,4; index wraps 0x3FF→0x000; wait is high for 3 cycles after the read is accepted.
- Write 0x11223344 to 0x020, then write 0xAABBCCDD with BE=4'b0101 -> a read of 0x020 returns 0x11BB33DD.
- Read burst of 7 immediately followed by a write to the burst's first address, accepted in IDLE while beats drain -> read beats return the old data, with 7 contiguous valids.
- Assert `Rstn` low during beat 3 of a read burst of 6 -> no further valids after reset; wait is 1 during reset and 0 one cycle after release.
- With `BACH_AVL_SLAVE_WAIT_INJECT_EN` defined, 100 random single writes then readback -> every stalled cycle has wait=1, all data matches, and the first stall occurs in a cycle that agrees with the seed 0xA5 LFSR sequence.
